// File: rtl/ro_freq_counter.sv
// ro_freq_counter: gated ring-oscillator edge counter with a Wishbone register interface
module ro_freq_counter #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int CNT_W = 32,
   parameter int NCH = 5
) (
   input  logic           wb_clk_i,
   input  logic           wb_rst_i,
   input  logic           wbs_stb_i,
   input  logic           wbs_cyc_i,
   input  logic           wbs_we_i,
   input  logic [3:0]     wbs_sel_i,
   input  logic [31:0]    wbs_adr_i,
   input  logic [31:0]    wbs_dat_i,
   output logic           wbs_ack_o,
   output logic [31:0]    wbs_dat_o,
   input  logic [NCH-1:0] ro_in,
   output logic           irq_o
);
   typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;
   state_t state, state_nxt;
   logic [NCH-1:0] s1, s2, s3;
   logic [CNT_W-1:0] count;
   logic [31:0] window, gate_cnt, rdata, bmask;
   logic [7:0] rise;
   logic [2:0] chan;
   logic [1:0] arm_cnt;
   logic irq_en, done, ovf, busy, acc, wr, go, stop, clr, rise_sel, unused_ok;
   assign acc = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~wbs_ack_o;
   assign wr = acc & wbs_we_i;
   assign bmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
   assign busy = state != IDLE;
   assign stop = wr & (wbs_adr_i[3:2] == 2'd0) & wbs_sel_i[0] & wbs_dat_i[1];
   assign go = wr & (wbs_adr_i[3:2] == 2'd0) & wbs_sel_i[0] & wbs_dat_i[0] & ~wbs_dat_i[1];
   assign clr = (go & ~busy) | (stop & busy);
   // padding to 8 lanes makes any chan >= NCH read a constant zero
   assign rise = 8'(s2 & ~s3);
   assign rise_sel = rise[chan];
   assign unused_ok = ^wbs_adr_i[1:0];
   always_comb begin
      rdata = (wbs_adr_i[3:2] == 2'd0) ? {23'd0, irq_en, 3'd0, chan, 2'd0} :
              (wbs_adr_i[3:2] == 2'd1) ? window :
              (wbs_adr_i[3:2] == 2'd2) ? 32'(count) : {29'd0, ovf, done, busy};
   end
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (go) state_nxt = ARM;
         ARM:  if (arm_cnt == 2'd2) state_nxt = (window == 32'd0) ? DONE : GATE;
         GATE: if (gate_cnt == 32'd1) state_nxt = DONE;
         DONE: state_nxt = IDLE;
      endcase
      if (stop && busy) state_nxt = IDLE;
   end
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state     <= IDLE;
         s1        <= '0;
         s2        <= '0;
         s3        <= '0;
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
         irq_o     <= 1'b0;
         arm_cnt   <= '0;
         gate_cnt  <= '0;
         count     <= '0;
         window    <= 32'd1000;
         chan      <= '0;
         irq_en    <= 1'b0;
         done      <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         state     <= state_nxt;
         s1        <= ro_in;
         s2        <= s1;
         s3        <= s2;
         wbs_ack_o <= acc;
         wbs_dat_o <= acc ? rdata : '0;
         irq_o     <= done & irq_en;
         arm_cnt   <= (state == ARM) ? arm_cnt + 2'd1 : 2'd0;
         gate_cnt  <= (state == ARM) ? window : (state == GATE) ? gate_cnt - 32'd1 : gate_cnt;
         if (state == GATE && rise_sel) begin
            if (&count) ovf <= 1'b1;
            else count <= count + 1'b1;
         end
         if (wr && wbs_adr_i[3:2] == 2'd0) begin
            if (wbs_sel_i[0] && !busy) chan <= wbs_dat_i[4:2];
            if (wbs_sel_i[1]) irq_en <= wbs_dat_i[8];
         end
         if (wr && wbs_adr_i[3:2] == 2'd1 && !busy) window <= (window & ~bmask) | (wbs_dat_i & bmask);
         if (wr && wbs_adr_i[3:2] == 2'd3 && wbs_sel_i[0]) begin
            if (wbs_dat_i[1]) done <= 1'b0;
            if (wbs_dat_i[2]) ovf <= 1'b0;
         end
         if (state == DONE) done <= 1'b1;
         if (clr) begin
            count <= '0;
            done  <= 1'b0;
            ovf   <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_ro_freq_counter.sv
// tb_ro_freq_counter: scoreboard bench driving two ro_freq_counter slaves on one Wishbone bus
`timescale 1ns/100ps
module tb_ro_freq_counter;
   localparam logic [31:0] B1 = 32'h3000_0000, B2 = 32'h3000_0100;
   typedef struct {string tag; logic [31:0] exp; int tol;} exp_t;
   logic clk = 1'b0, rst = 1'b1;
   logic stb = 1'b0, cyc = 1'b0, we = 1'b0;
   logic [3:0] sel = 4'h0;
   logic [31:0] adr = '0, wdat = '0, dat1, dat2;
   logic ack1, ack2, irq1, irq2;
   logic [4:0] ro = '0;
   int half[5] = '{50, 0, 0, 0, 0};
   int ph[5] = '{0, 0, 0, 0, 0};
   int cycles = 0, ack_hi = 0, n_chk = 0, n_fail = 0;
   exp_t sb[$];
   ro_freq_counter #(.BASE_ADDR(B1)) u1 (
      .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
      .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack1), .wbs_dat_o(dat1),
      .ro_in(ro), .irq_o(irq1));
   ro_freq_counter #(.BASE_ADDR(B2), .CNT_W(8)) u2 (
      .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
      .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack2), .wbs_dat_o(dat2),
      .ro_in(ro), .irq_o(irq2));
   always #5 clk = ~clk;
   always @(posedge clk) begin
      cycles <= cycles + 1;
      if (ack1 | ack2) ack_hi <= ack_hi + 1;
   end
   // oscillators tick on half-ns offsets so they never share a timestep with clk edges
   initial begin
      #0.5;
      forever begin
         #1;
         for (int i = 0; i < 5; i++)
            if (half[i] != 0) begin
               ph[i] = ph[i] + 1;
               if (ph[i] >= half[i]) begin
                  ph[i] = 0;
                  ro[i] = ~ro[i];
               end
            end
      end
   end
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp, input int tol = 0);
      n_chk++;
      if (((obs > exp) ? obs - exp : exp - obs) > 32'(tol)) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), want %0d +/- %0d", tag, obs, obs, exp, tol);
      end
   endtask
   task automatic wb(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                     output logic got, output logic [31:0] q);
      @(negedge clk);
      adr = a; we = w; wdat = d; sel = s; stb = 1'b1; cyc = 1'b1;
      got = 1'b0; q = '0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk); #1;
         if (ack1 | ack2) begin
            got = 1'b1;
            q = a[8] ? dat2 : dat1;
         end
      end
      @(negedge clk);
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
   endtask
   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
      logic got;
      logic [31:0] q;
      wb(a, 1'b1, d, s, got, q);
      check("wr_ack", 32'(got), 32'd1);
   endtask
   task automatic rd(input logic [31:0] a, input string tag, input logic [31:0] exp, input int tol = 0);
      exp_t e;
      logic got;
      logic [31:0] q;
      e.tag = tag; e.exp = exp; e.tol = tol;
      sb.push_back(e);
      wb(a, 1'b0, '0, 4'hF, got, q);
      e = sb.pop_front();
      check({e.tag, "_ack"}, 32'(got), 32'd1);
      if (got) check(e.tag, q, e.exp, e.tol);
   endtask
   task automatic start(input logic [31:0] b, input logic [31:0] d, output int t0);
      wr(b + 32'hC, 32'h6);
      wr(b, d);
      t0 = cycles;
   endtask
   task automatic wait_irq(input logic which, input int t0, input int budget, output int lat);
      lat = -1;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (which ? irq2 : irq1) begin
            lat = cycles - t0;
            break;
         end
      end
   endtask
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int t0, lat, a0;
      logic got;
      logic [31:0] q;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      check("irq1_rst", 32'(irq1), 32'd0);
      check("irq2_rst", 32'(irq2), 32'd0);
      a0 = ack_hi;
      rd(B1 + 32'h0, "ctrl_rst", 32'h0);
      rd(B1 + 32'h4, "window_rst", 32'd1000);
      rd(B1 + 32'h8, "count_rst", 32'h0);
      rd(B1 + 32'hC, "status_rst", 32'h0);
      @(posedge clk); #1;
      check("ack_pulses", 32'(ack_hi - a0), 32'd4);
      // period 10 on channel 0, default window, interrupt enabled
      start(B1, 32'h101, t0);
      wait_irq(1'b0, t0, 1100, lat);
      check("lat_1000", 32'(lat), 32'd1005);
      rd(B1 + 32'h8, "count_p10", 32'd100, 1);
      rd(B1 + 32'hC, "status_done", 32'h2);
      rd(B1 + 32'h0, "ctrl_rb", 32'h100);
      check("irq_set", 32'(irq1), 32'd1);
      wr(B1 + 32'hC, 32'h2);
      @(posedge clk); #1;
      check("irq_w1c", 32'(irq1), 32'd0);
      rd(B1 + 32'hC, "status_clr", 32'h0);
      // a second start and a WINDOW write during the gate must both be ignored
      start(B1, 32'h101, t0);
      repeat (300) @(posedge clk);
      wr(B1, 32'h101);
      wr(B1 + 32'h4, 32'd50);
      wait_irq(1'b0, t0, 1100, lat);
      check("lat_restart", 32'(lat), 32'd1005);
      rd(B1 + 32'h8, "count_restart", 32'd100, 1);
      rd(B1 + 32'h4, "window_busy", 32'd1000);
      // abort 200 cycles into the gate
      start(B1, 32'h101, t0);
      repeat (203) @(posedge clk);
      wr(B1, 32'h2);
      rd(B1 + 32'hC, "status_abort", 32'h0);
      rd(B1 + 32'h8, "count_abort", 32'h0);
      check("irq_abort", 32'(irq1), 32'd0);
      // start and abort together leave the block idle
      wr(B1, 32'h103);
      rd(B1 + 32'hC, "status_st_ab", 32'h0);
      // channel select: only ro[3] toggles
      half[0] = 0; half[3] = 30; ph[3] = 0;
      wr(B1 + 32'h4, 32'd600);
      start(B1, 32'h10D, t0);
      wait_irq(1'b0, t0, 700, lat);
      check("lat_600", 32'(lat), 32'd605);
      rd(B1 + 32'h8, "count_ch3", 32'd100, 1);
      start(B1, 32'h119, t0);
      wait_irq(1'b0, t0, 700, lat);
      check("lat_ch6", 32'(lat), 32'd605);
      rd(B1 + 32'h8, "count_ch6", 32'h0);
      rd(B1 + 32'h0, "ctrl_ch6", 32'h118);
      // 8-bit counter saturates and flags overflow
      half[0] = 20; ph[0] = 0;
      wr(B2 + 32'h4, 32'd2000);
      start(B2, 32'h101, t0);
      wait_irq(1'b1, t0, 2100, lat);
      check("lat_2000", 32'(lat), 32'd2005);
      rd(B2 + 32'h8, "count_sat", 32'd255);
      rd(B2 + 32'hC, "status_ovf", 32'h6);
      wr(B2 + 32'h4, 32'd0);
      start(B2, 32'h101, t0);
      wait_irq(1'b1, t0, 20, lat);
      check("lat_win0", 32'(lat), 32'd5);
      rd(B2 + 32'h8, "count_win0", 32'h0);
      rd(B2 + 32'hC, "status_win0", 32'h2);
      // byte-lane write touches only the low byte
      wr(B1 + 32'h4, 32'hFFFF_FF55, 4'b0001);
      rd(B1 + 32'h4, "window_lane", 32'h255);
      // out-of-range offset is never acknowledged
      wb(B1 + 32'h10, 1'b0, '0, 4'hF, got, q);
      check("noack", 32'(got), 32'd0);
      // reset in the middle of a measurement
      start(B1, 32'h101, t0);
      repeat (100) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      rd(B1 + 32'hC, "status_mrst", 32'h0);
      rd(B1 + 32'h4, "window_mrst", 32'd1000);
      rd(B1 + 32'h0, "ctrl_mrst", 32'h0);
      check("irq_mrst", 32'(irq1), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
